// File: rtl/regn_seq_ctrl_pkg.sv
// Shared definitions for the regN sequencer, its register stage and the bench.
package regn_seq_ctrl_pkg;

    // Default data width of the start value and the downstream register.
    localparam int DEF_WIDTH = 8;
    // Default width of the increment-count field.
    localparam int DEF_STEPW = 8;

    // Sequencer states, fixed 2-bit encoding so external checkers can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A sequence is in flight in every state except IDLE.
    function automatic logic is_busy(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/regn_seq_ctrl_if.sv
// Request handshake and register-control bundle between a requester and the sequencer.
//
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high. req_ready is high only while the sequencer is idle; the requester
// may hold req_valid high at any time and it is simply not accepted until then.
// req_start/req_steps are only looked at in the accepting cycle.
interface regn_seq_ctrl_if
    import regn_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEPW = DEF_STEPW
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_start;
    logic [STEPW-1:0] req_steps;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] reg_in;
    logic             reg_ld;
    logic             reg_inc;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] exp_val;

    // Requester side: issues requests and run-time controls, observes status.
    modport master (
        output req_valid, req_start, req_steps, pause, abort,
        input  req_ready, reg_in, reg_ld, reg_inc, busy, done, exp_val
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_start, req_steps, pause, abort,
        output req_ready, reg_in, reg_ld, reg_inc, busy, done, exp_val
    );
endinterface

// File: rtl/regN.sv
// Load/increment register stage driven by the sequencer; load wins over increment.
module regN
    import regn_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_in,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_out
);
    logic [WIDTH-1:0] r_out;

    // Register value: load the input, else count up with natural wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
        end else if (i_ld) begin
            r_out <= i_in;
        end else if (i_inc) begin
            r_out <= r_out + WIDTH'(1);
        end
    end

    assign o_out = r_out;
endmodule

// File: rtl/regn_seq_ctrl.sv
// Sequencer: accepts a request, loads the start value into regN, then issues
// the programmed number of increment pulses, with pause/abort and a done pulse.
// exp_val mirrors what regN should hold so a checker can compare against it.
module regn_seq_ctrl
    import regn_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEPW = DEF_STEPW
) (
    input  logic              clk,
    input  logic              rst,
    regn_seq_ctrl_if.slave    bus,
    output state_t            o_dbg_state
);
    state_t           r_state;
    logic [WIDTH-1:0] r_start;
    logic [STEPW-1:0] r_remain;
    logic [WIDTH-1:0] r_exp;

    logic             w_in_load;
    logic             w_in_step;
    logic             w_ld;
    logic             w_inc;

    // Control decode uses only the state and pause/abort, never the req_* inputs,
    // so the reg_* outputs carry no combinational path from the request side.
    assign w_in_load = (r_state == ST_LOAD);
    assign w_in_step = (r_state == ST_STEP);
    assign w_ld      = w_in_load & ~bus.abort;
    assign w_inc     = w_in_step & ~bus.pause & ~bus.abort;

    // Sequencer FSM with the captured request, remaining-step counter and mirror.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_start  <= '0;
            r_remain <= '0;
            r_exp    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // req_ready is implied high here.
                    if (bus.req_valid) begin
                        r_start  <= bus.req_start;
                        r_remain <= bus.req_steps;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Abort cancels the load itself; pause has no effect here.
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_exp   <= r_start;
                        r_state <= (r_remain == '0) ? ST_DONE : ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_inc) begin
                        // STEP is entered only with r_remain > 0 and left on the
                        // last decrement, so the counter cannot underflow.
                        r_remain <= r_remain - STEPW'(1);
                        r_exp    <= r_exp + WIDTH'(1);
                        if (r_remain == STEPW'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // No back-to-back acceptance: always pass through IDLE.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.reg_in    = r_start;
    assign bus.reg_ld    = w_ld;
    assign bus.reg_inc   = w_inc;
    assign bus.busy      = is_busy(r_state);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.exp_val   = r_exp;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_regn_seq_ctrl.sv
// Bench for regn_seq_ctrl driving a regN stage: directed scenarios plus random
// sequences, each checked cycle by cycle against a timeline model of the request.
module tb_regn_seq_ctrl;
    import regn_seq_ctrl_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int SW = DEF_STEPW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regn_seq_ctrl_if #(.WIDTH(W), .STEPW(SW)) bus ();
    state_t         dbg_state;
    logic [W-1:0]   reg_out;

    regn_seq_ctrl #(.WIDTH(W), .STEPW(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    regN #(.WIDTH(W)) u_reg (
        .clk   (clk),
        .rst   (rst),
        .i_ld  (bus.reg_ld),
        .i_in  (bus.reg_in),
        .i_inc (bus.reg_inc),
        .o_out (reg_out)
    );

    // ---------------- scoreboard ----------------
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mdl_val;          // value regN should hold right now
    logic [W-1:0] exp_q[$];         // final values of sequences expected to complete

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver + timeline model ----------------
    // Cycle k counts from the acceptance edge: k=1 is the load cycle, step cycles
    // start at k=2. pmask[k] is the pause level driven in step cycle k.
    // abort_cyc < 1 means no abort; an abort at or after the done cycle is ignored.
    task automatic run_seq(input logic [W-1:0] start, input logic [SW-1:0] steps,
                           input logic [63:0] pmask, input int abort_cyc, input bit hold);
        int   cnt;
        int   c;
        int   done_cyc;
        int   last;
        bit   aborted;
        bit   e_ld;
        bit   e_inc;
        bit   e_done;
        bit   e_busy;
        logic [W-1:0] fin;

        // The done cycle follows the step cycle carrying the N-th unpaused increment.
        cnt = 0;
        c   = 2;
        while (cnt < int'(steps) && c < 62) begin
            if (!pmask[c]) cnt++;
            c++;
        end
        done_cyc = c;
        aborted  = (abort_cyc >= 1) && (abort_cyc < done_cyc);
        last     = aborted ? abort_cyc + 1 : done_cyc + 1;
        if (!aborted) exp_q.push_back(start + W'(steps));

        // Acceptance cycle; pause/abort are meaningless in IDLE.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_start = start;
        bus.req_steps = steps;
        bus.pause     = 1'($urandom_range(0, 1));
        bus.abort     = 1'($urandom_range(0, 1));
        #1;
        chk("ready_before_accept", 32'(bus.req_ready), 32'd1);
        chk("busy_before_accept", 32'(bus.busy), 32'd0);
        @(posedge clk);

        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            bus.req_valid = (k < last) ? hold : 1'b0;
            bus.req_start = W'($urandom);
            bus.req_steps = SW'($urandom);
            bus.pause     = (k >= 2 && k < done_cyc) ? pmask[k] : 1'($urandom_range(0, 1));
            if (k == abort_cyc)
                bus.abort = 1'b1;
            else if (k < done_cyc)
                bus.abort = 1'b0;
            else
                bus.abort = 1'($urandom_range(0, 1));
            #1;
            e_ld   = (k == 1) && !(aborted && abort_cyc == 1);
            e_inc  = (k >= 2) && (k < done_cyc) && !pmask[k] && !(aborted && k >= abort_cyc);
            e_done = !aborted && (k == done_cyc);
            e_busy = (k < last);
            chk($sformatf("reg_ld k=%0d", k), 32'(bus.reg_ld), 32'(e_ld));
            chk($sformatf("reg_inc k=%0d", k), 32'(bus.reg_inc), 32'(e_inc));
            chk($sformatf("done k=%0d", k), 32'(bus.done), 32'(e_done));
            chk($sformatf("busy k=%0d", k), 32'(bus.busy), 32'(e_busy));
            chk($sformatf("req_ready k=%0d", k), 32'(bus.req_ready), 32'(!e_busy));
            chk($sformatf("reg_in k=%0d", k), 32'(bus.reg_in), 32'(start));
            chk($sformatf("reg_out k=%0d", k), 32'(reg_out), 32'(mdl_val));
            chk($sformatf("exp_val k=%0d", k), 32'(bus.exp_val), 32'(mdl_val));
            if (e_done) begin
                fin = exp_q.pop_front();
                chk("final_reg_out", 32'(reg_out), 32'(fin));
                chk("final_exp_val", 32'(bus.exp_val), 32'(fin));
            end
            @(posedge clk);
            if (e_ld)  mdl_val = start;
            if (e_inc) mdl_val = mdl_val + W'(1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_ld"}, 32'(bus.reg_ld), 32'd0);
        chk({tag, "_inc"}, 32'(bus.reg_inc), 32'd0);
        chk({tag, "_reg_in"}, 32'(bus.reg_in), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_exp_val"}, 32'(bus.exp_val), 32'd0);
        chk({tag, "_reg_out"}, 32'(reg_out), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- directed + random steps ----------------
    initial begin
        logic [63:0] pm;
        int          ac;
        logic [W-1:0] rs;
        logic [SW-1:0] rn;

        bus.req_valid = 1'b0;
        bus.req_start = '0;
        bus.req_steps = '0;
        bus.pause     = 1'b0;
        bus.abort     = 1'b0;
        mdl_val       = '0;

        // Power-on reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("por");
        rst = 1'b1;

        // Basic sequence: done five cycles after acceptance, ends at 0x13.
        run_seq(8'h10, 8'd3, 64'h0, 0, 1'b0);
        // Zero steps: load only, done two cycles after acceptance.
        run_seq(8'hAA, 8'd0, 64'h0, 0, 1'b0);
        // Wrap through 0xFF/0x00 to 0x02.
        run_seq(8'hFE, 8'd4, 64'h0, 0, 1'b0);
        // Pause for the two step cycles after the first increment: done at T+9.
        run_seq(8'h00, 8'd5, 64'h18, 0, 1'b0);
        // Abort after one increment, with req_valid held high while busy.
        run_seq(8'h20, 8'd4, 64'h0, 3, 1'b1);
        chk("abort_final_out", 32'(reg_out), 32'h21);
        // Abort in the load cycle: nothing is loaded.
        run_seq(8'h44, 8'd2, 64'h0, 1, 1'b0);
        // Abort asserted in the done cycle is ignored.
        run_seq(8'h5C, 8'd2, 64'h0, 4, 1'b1);

        // Reset in the middle of STEP.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_start = 8'h33;
        bus.req_steps = 8'd6;
        bus.pause     = 1'b0;
        bus.abort     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_inc", 32'(bus.reg_inc), 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mdl_val = '0;
        #1;
        chk("after_reset_ready", 32'(bus.req_ready), 32'd1);
        chk("after_reset_out", 32'(reg_out), 32'h00);

        // Random sequences.
        for (int n = 0; n < 24; n++) begin
            rs = W'($urandom);
            rn = SW'($urandom_range(0, 10));
            pm = {32'h0, 32'($urandom) & 32'h001F_FFFC};
            if ($urandom_range(0, 3) == 0) pm = '0;
            ac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0;
            run_seq(rs, rn, pm, ac, 1'($urandom_range(0, 1)));
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
